if_prefetch: RTL and testbench

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch.sv | 77 +++++++
 tb/tb_if_prefetch.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/if_prefetch.sv
// if_prefetch: instruction prefetch queue between instruction memory and decode
// Ports: clk, reset (async active-low); in_mem_addr/in_mem_en fetch request,
// in_mem response word one cycle later; redirect/redirect_addr flush and restart;
// instr/instr_pc/instr_valid/instr_ready head-of-queue handshake toward decode.
// Optional: define IF_PREFETCH_STALL_CNT_EN to add the 32-bit stall_cnt output.
module if_prefetch #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] in_mem_addr,
  output logic              in_mem_en,
  input  logic [DATA_W-1:0] in_mem,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef IF_PREFETCH_STALL_CNT_EN
  , output logic [31:0]     stall_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [DATA_W-1:0] q_data [DEPTH];
  logic [ADDR_W-1:0] q_pc [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic [ADDR_W-1:0] fetch_pc, pend_pc;
  logic pend, push, pop;
  assign instr_valid = count != '0;
  assign instr = q_data[rd_ptr];
  assign instr_pc = q_pc[rd_ptr];
  assign pop = instr_valid && instr_ready && !redirect;
  // a response returning during a redirect belongs to the old stream
  assign push = pend && !redirect;
  assign in_mem_addr = fetch_pc;
  // reserve a slot for the in-flight response so every returning word fits
  assign in_mem_en = reset && !redirect && (count - CW'(pop) + CW'(pend)) < CW'(DEPTH);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      fetch_pc <= RESET_PC;
      pend <= 1'b0;
      pend_pc <= RESET_PC;
    end else begin
      pend <= in_mem_en;
      if (in_mem_en) pend_pc <= fetch_pc;
      if (redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count <= '0;
        fetch_pc <= redirect_addr & ~ADDR_W'(3);
      end else begin
        if (in_mem_en) fetch_pc <= fetch_pc + ADDR_W'(4);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        if (push) wr_ptr <= wr_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  always_ff @(posedge clk)
    if (push) begin
      q_data[wr_ptr] <= in_mem;
      q_pc[wr_ptr] <= pend_pc;
    end
`ifdef IF_PREFETCH_STALL_CNT_EN
  always_ff @(posedge clk or negedge reset)
    if (!reset) stall_cnt <= '0;
    else if (instr_ready && !instr_valid && stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
`endif
endmodule

// File: tb/tb_if_prefetch.sv
// tb_if_prefetch: directed bench with a queue-level reference model for if_prefetch
module tb_if_prefetch;
  localparam int D = 4;
  localparam logic [31:0] RPC = 32'h100;
  logic clk = 1'b0, reset = 1'b0, redirect = 1'b0, instr_ready = 1'b0;
  logic in_mem_en, instr_valid;
  logic [31:0] in_mem_addr, in_mem, instr, instr_pc;
  logic [31:0] redirect_addr = '0, last_addr = '0;
`ifdef IF_PREFETCH_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  if_prefetch #(.ADDR_W(32), .DATA_W(32), .DEPTH(D), .RESET_PC(RPC)) dut (
    .clk(clk), .reset(reset), .in_mem_addr(in_mem_addr), .in_mem_en(in_mem_en),
    .in_mem(in_mem), .redirect(redirect), .redirect_addr(redirect_addr),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
`ifdef IF_PREFETCH_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction
  // memory answers exactly one cycle after the request
  always @(posedge clk) last_addr <= in_mem_addr;
  assign in_mem = mem_fn(last_addr);
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;
  ent_t mq[$];
  logic [31:0] inflight[$];
  logic [31:0] m_fpc = RPC, m_stall = '0, m_a;
  bit m_v, m_pop, m_en;
  ent_t m_e;
  always @(negedge clk) begin
    if (!reset) begin
      mq.delete();
      inflight.delete();
      m_fpc = RPC;
      m_stall = '0;
      check("m_rst_en", in_mem_en, 0);
      check("m_rst_valid", instr_valid, 0);
      check("m_rst_addr", in_mem_addr, RPC);
`ifdef IF_PREFETCH_STALL_CNT_EN
      check("m_rst_stall", stall_cnt, 0);
`endif
    end else begin
      m_v = mq.size() != 0;
      m_pop = m_v && instr_ready && !redirect;
      m_en = !redirect && (mq.size() - int'(m_pop) + inflight.size()) < D;
      check("m_en", in_mem_en, 32'(m_en));
      if (m_en) check("m_addr", in_mem_addr, m_fpc);
      check("m_valid", instr_valid, 32'(m_v));
      if (m_v) begin
        check("m_pc", instr_pc, mq[0].pc);
        check("m_instr", instr, mq[0].data);
      end
`ifdef IF_PREFETCH_STALL_CNT_EN
      check("m_stall", stall_cnt, m_stall);
`endif
      if (instr_ready && !m_v && m_stall != 32'hFFFF_FFFF) m_stall++;
      if (redirect) begin
        mq.delete();
        inflight.delete();
        m_fpc = redirect_addr & ~32'd3;
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (inflight.size() != 0) begin
          m_a = inflight.pop_front();
          m_e.pc = m_a;
          m_e.data = mem_fn(m_a);
          mq.push_back(m_e);
        end
        if (m_en) begin
          inflight.push_back(m_fpc);
          m_fpc += 32'd4;
        end
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    int k = 0;
    #1;
    while (!instr_valid && k < 10) begin
      tick();
      #1;
      k++;
    end
    check({name, "_v"}, instr_valid, 1);
    check(name, instr_pc, exp_pc);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    int n;
    logic [23:0] pat = 24'b1011_0010_1110_0001_0110_1101;
    instr_ready = 1'b1;
    repeat (3) tick();
    #1;
    check("rst_en", in_mem_en, 0);
    check("rst_addr", in_mem_addr, RPC);
    check("rst_valid", instr_valid, 0);
    tick();
    reset = 1'b1;
    #1;
    check("rel_en0", in_mem_en, 1);
    check("rel_a0", in_mem_addr, 32'h100);
    check("rel_v0", instr_valid, 0);
    tick();
    #1;
    check("rel_a1", in_mem_addr, 32'h104);
    check("rel_v1", instr_valid, 0);
    tick();
    #1;
    check("rel_a2", in_mem_addr, 32'h108);
    check("rel_v2", instr_valid, 1);
    check("rel_pc2", instr_pc, 32'h100);
    check("rel_instr2", instr, mem_fn(32'h100));
    tick();
    reset = 1'b0;
    instr_ready = 1'b0;
    #1;
    check("async_en", in_mem_en, 0);
    check("async_valid", instr_valid, 0);
    tick();
    reset = 1'b1;
    n = 0;
    repeat (20) begin
      #1;
      if (in_mem_en) n++;
      tick();
    end
    #1;
    check("full_reqs", n, 4);
    check("full_en", in_mem_en, 0);
    check("full_valid", instr_valid, 1);
    check("full_pc", instr_pc, 32'h100);
    instr_ready = 1'b1;
    repeat (6) tick();
    for (int i = 0; i < 24; i++) begin
      instr_ready = pat[i];
      tick();
    end
    instr_ready = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    redirect = 1'b1;
    redirect_addr = 32'h2002;
    #1;
    check("rd_en", in_mem_en, 0);
    tick();
    redirect = 1'b0;
    #1;
    check("rd_next_en", in_mem_en, 1);
    check("rd_next_addr", in_mem_addr, 32'h2000);
    check("rd_stale", instr_valid, 0);
    tick();
    #1;
    check("rd_gap", instr_valid, 0);
    wait_valid("rd_first_pc", 32'h2000);
    tick();
    redirect = 1'b1;
    redirect_addr = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    #1;
    check("wrap_a0", in_mem_addr, 32'hFFFF_FFF8);
    tick();
    #1;
    check("wrap_a1", in_mem_addr, 32'hFFFF_FFFC);
    tick();
    #1;
    check("wrap_a2", in_mem_addr, 32'h0000_0000);
    check("wrap_en2", in_mem_en, 1);
    repeat (4) tick();
    #1;
    check("rpr_pre_valid", instr_valid, 1);
    redirect = 1'b1;
    redirect_addr = 32'h3000;
    #1;
    check("rpr_en", in_mem_en, 0);
    tick();
    redirect = 1'b0;
    #1;
    check("rpr_empty", instr_valid, 0);
    check("rpr_addr", in_mem_addr, 32'h3000);
    tick();
    #1;
    check("rpr_empty2", instr_valid, 0);
    wait_valid("rpr_first_pc", 32'h3000);
    tick();
    redirect = 1'b1;
    redirect_addr = 32'h4000;
    #1;
    check("b2b_en0", in_mem_en, 0);
    tick();
    redirect_addr = 32'h5006;
    #1;
    check("b2b_en1", in_mem_en, 0);
    tick();
    redirect = 1'b0;
    #1;
    check("b2b_addr", in_mem_addr, 32'h5004);
    wait_valid("b2b_first_pc", 32'h5004);
`ifdef IF_PREFETCH_STALL_CNT_EN
    tick();
    reset = 1'b0;
    #1;
    check("stall_rst", stall_cnt, 0);
    tick();
    reset = 1'b1;
    redirect = 1'b1;
    redirect_addr = RPC;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    #1;
    check("stall_three", stall_cnt, 3);
    check("stall_valid", instr_valid, 1);
    repeat (4) begin
      tick();
      #1;
      check("stall_hold", stall_cnt, 3);
    end
`endif
    repeat (3) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
